regfile_2w2r: RTL and testbench
===============================

# regfile_2w2r

Parametrised multi-ported register file for the processor datapath: two registered read ports, two write ports, write-first bypass, an optional hardwired-zero register and a sequential clear engine. It keeps the same read and write port style as the existing 16×32 register file and adds the generalisation and state the current core needs.

## Interface
Parameters:
- WIDTH, 32, data word width in bits (≥ 4).
- AW, 4, address width; DEPTH = 2**AW entries.
- ZERO_REG, 0, when 1 entry 0 reads as 0 and ignores writes.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- A1  in  AW  read address, port 1.
- A2  in  AW  read address, port 2.
- A3  in  AW  write address, port 3.
- WE3  in  1  write enable, port 3.
- WD3  in  WIDTH  write data, port 3.
- A4  in  AW  write address, port 4.
- WE4  in  1  write enable, port 4.
- WD4  in  WIDTH  write data, port 4.
- CLR  in  1  one-cycle request to sweep all entries to 0.
- RD1  out  WIDTH  registered read data, port 1.
- RD2  out  WIDTH  registered read data, port 2.
- BUSY  out  1  high while a clear sweep is in progress.

## Operation
- Storage is DEPTH × WIDTH flops. Reset is asynchronous, active-high; the polarity and synchronicity are fixed.
- While reset is high:
  - entry i holds i, zero-extended or truncated to WIDTH;
  - RD1 = RD2 = 0, BUSY = 0, FSM = IDLE, sweep pointer = 0.
- Writes:
  - On each edge with BUSY = 0, WE3 writes WD3 to entry A3 and WE4 writes WD4 to entry A4.
  - If both enables are set and A3 == A4, WD4 wins.
  - With ZERO_REG = 1, writes to address 0 are dropped.
- Reads: on every edge, RDn <= the post-edge content of entry An (write-first bypass).
  - A write landing on An at the same edge is returned, with port-4 priority applied.
  - With ZERO_REG = 1 and An == 0, RDn <= 0.
  - Reads are always serviced, including while BUSY = 1.
- Clear FSM has two states, IDLE and SWEEP:
  - IDLE → SWEEP on an edge with CLR = 1. Pointer <= 0 and BUSY <= 1. Writes presented on that same edge are still performed.
  - In SWEEP, each edge writes 0 to entry ptr and increments ptr. When ptr == DEPTH-1, the FSM returns to IDLE and BUSY <= 0 at that edge.
  - In SWEEP, WE3 and WE4 are ignored, and their data is lost. The upstream side must stall on BUSY.
  - CLR while in SWEEP is ignored; a sweep is never restarted or extended.
  - Read bypass in SWEEP: a read of entry ptr at the clearing edge returns 0.
- Reset asserted mid-sweep aborts the sweep immediately. Contents return to their index values and BUSY goes to 0.
- Pointer arithmetic is AW bits. The terminal test is ptr == DEPTH-1, so no wrap-around ever occurs.

## Timing
- Read latency is 1 cycle: An is sampled at edge k and RDn is valid after edge k; RDn holds until the next edge.
- Write latency is 0 cycles to a same-edge read (bypass), and 1 cycle to reads at later edges.
- A clear spans exactly DEPTH edges: BUSY is high for DEPTH cycles, starting the cycle after the CLR edge.
- Entry k is cleared at sweep edge k+1, counting the CLR edge as edge 0.
- Writes are accepted again at the edge after BUSY falls.
- No combinational path runs from any input to any output.

## Test plan
- Reset, then read A1 = 5 and A2 = 15 at the next edge → RD1 = 5, RD2 = 15. During reset, RD1 = RD2 = BUSY = 0.
- Bypass and conflict: WE3 = 1, A3 = 7, WD3 = 0xAAAA0000 and WE4 = 1, A4 = 7, WD4 = 0x5555FFFF, with A1 = 7 on the same edge → RD1 = 0x5555FFFF at once. A read of 7 on the next edge gives the same value.
- ZERO_REG = 1: write 0xDEADBEEF to address 0, then read A1 = 0 → RD1 = 0. A write of 0xDEADBEEF to address 3 reads back 0xDEADBEEF.
- Clear with DEPTH = 16: pulse CLR → BUSY high for exactly 16 cycles.
  - Read A1 = 15 during the sweep returns 15 until the last sweep edge, which returns 0.
  - WE3 of 0x1234 to address 2 mid-sweep is dropped; address 2 reads 0 afterwards.
  - A second CLR mid-sweep does not extend BUSY.
- Reset mid-sweep: assert reset after 6 sweep cycles → BUSY = 0 immediately. After release, entry 3 reads 3 and entry 10 reads 10.
- Parameter sweep at WIDTH = 8, AW = 3:
  - reset value of entry 7 is 7;
  - a write of 0xFF to address 7 reads 0xFF;
  - a clear takes 8 cycles.

Source files
------------

// File: rtl/regfile_2w2r.sv
// regfile_2w2r: parametrised register file with two registered read ports,
// two write ports, write-first read bypass, optional hardwired-zero entry 0
// and a sequential clear engine that sweeps every entry to zero.
//
// Parameters:
//   WIDTH    data word width in bits (>= 4)
//   AW       address width; DEPTH = 2**AW entries
//   ZERO_REG when 1, entry 0 reads as 0 and ignores writes
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset (entry i <= i)
//   A1, A2       read addresses; RD1/RD2 are registered (1-cycle latency)
//   A3/WE3/WD3   write port 3
//   A4/WE4/WD4   write port 4 (wins over port 3 on an address collision)
//   CLR          one-cycle request to start a clear sweep
//   RD1, RD2     registered read data (post-edge content of the entry)
//   BUSY         high while a clear sweep is in progress
//
// Handshake: BUSY is a plain status flag, not a ready signal. While BUSY
// is high every write presented is discarded, so the upstream side must
// stall on BUSY; reads are serviced in every cycle regardless of BUSY.
module regfile_2w2r #(
    parameter int WIDTH    = 32,
    parameter int AW       = 4,
    parameter int ZERO_REG = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [AW-1:0]    A1,
    input  logic [AW-1:0]    A2,
    input  logic [AW-1:0]    A3,
    input  logic             WE3,
    input  logic [WIDTH-1:0] WD3,
    input  logic [AW-1:0]    A4,
    input  logic             WE4,
    input  logic [WIDTH-1:0] WD4,
    input  logic             CLR,
    output logic [WIDTH-1:0] RD1,
    output logic [WIDTH-1:0] RD2,
    output logic             BUSY
);

    localparam int DEPTH = 2 ** AW;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t          state, state_next;
    logic [AW-1:0]   ptr, ptr_next;
    logic [WIDTH-1:0] mem      [DEPTH];
    logic [WIDTH-1:0] mem_next [DEPTH];
    logic             wr3_ok, wr4_ok;
    logic [WIDTH-1:0] rd1_next, rd2_next;

    // Writes are only honoured outside a sweep; address 0 is read-only
    // when the hardwired-zero option is enabled.
    always_comb begin
        wr3_ok = WE3 && (state == IDLE) && !((ZERO_REG != 0) && (A3 == '0));
        wr4_ok = WE4 && (state == IDLE) && !((ZERO_REG != 0) && (A4 == '0));
    end

    // Post-edge storage image. Port 4 is applied after port 3 so it wins
    // on a collision; the sweep write replaces normal writes in SWEEP.
    always_comb begin
        mem_next = mem;
        if (state == SWEEP) begin
            mem_next[ptr] = '0;
        end else begin
            if (wr3_ok) mem_next[A3] = WD3;
            if (wr4_ok) mem_next[A4] = WD4;
        end
    end

    // Reads return the post-edge image, which gives write-first bypass
    // (including the clearing write of the current sweep entry).
    always_comb begin
        rd1_next = ((ZERO_REG != 0) && (A1 == '0)) ? '0 : mem_next[A1];
        rd2_next = ((ZERO_REG != 0) && (A2 == '0)) ? '0 : mem_next[A2];
    end

    // Clear FSM next-state. The sweep ends on the edge that clears the
    // last entry, so the pointer never wraps. CLR during SWEEP is ignored.
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        case (state)
            IDLE: begin
                if (CLR) begin
                    state_next = SWEEP;
                    ptr_next   = '0;
                end
            end
            SWEEP: begin
                ptr_next = ptr + AW'(1);
                if (ptr == AW'(DEPTH - 1)) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                ptr_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
        end
    end

    // Reset image: each entry holds its own index (truncated to WIDTH).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= WIDTH'(i);
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= mem_next[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RD1 <= '0;
            RD2 <= '0;
        end else begin
            RD1 <= rd1_next;
            RD2 <= rd2_next;
        end
    end

    // BUSY comes straight from the state register: no input-to-output path.
    assign BUSY = (state == SWEEP);

endmodule

// File: tb/tb_regfile_2w2r.sv
// Bench for regfile_2w2r. Three instances share clock, reset and stimulus:
//   k=0 default (32-bit, 16 entries), k=1 ZERO_REG=1, k=2 WIDTH=8/AW=3
//   (the small instance sees the low address/data bits).
// The reference model is a plain array per instance plus a count of sweep
// edges done; it is advanced once per clock edge in cyc().
module tb_regfile_2w2r;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // ---------------- stimulus ----------------
    logic [3:0]  a1 = '0, a2 = '0, a3 = '0, a4 = '0;
    logic        we3 = 1'b0, we4 = 1'b0, clr = 1'b0;
    logic [31:0] wd3 = '0, wd4 = '0;

    logic [31:0] rd1_m, rd2_m, rd1_z, rd2_z;
    logic [7:0]  rd1_s, rd2_s;
    logic        busy_m, busy_z, busy_s;

    regfile_2w2r dut (
        .clk(clk), .reset(reset), .A1(a1), .A2(a2), .A3(a3), .WE3(we3), .WD3(wd3),
        .A4(a4), .WE4(we4), .WD4(wd4), .CLR(clr), .RD1(rd1_m), .RD2(rd2_m), .BUSY(busy_m)
    );

    regfile_2w2r #(.ZERO_REG(1)) dut_z (
        .clk(clk), .reset(reset), .A1(a1), .A2(a2), .A3(a3), .WE3(we3), .WD3(wd3),
        .A4(a4), .WE4(we4), .WD4(wd4), .CLR(clr), .RD1(rd1_z), .RD2(rd2_z), .BUSY(busy_z)
    );

    regfile_2w2r #(.WIDTH(8), .AW(3)) dut_s (
        .clk(clk), .reset(reset), .A1(a1[2:0]), .A2(a2[2:0]), .A3(a3[2:0]), .WE3(we3),
        .WD3(wd3[7:0]), .A4(a4[2:0]), .WE4(we4), .WD4(wd4[7:0]), .CLR(clr),
        .RD1(rd1_s), .RD2(rd2_s), .BUSY(busy_s)
    );

    logic [31:0] o_rd1 [3];
    logic [31:0] o_rd2 [3];
    logic        o_busy [3];
    assign o_rd1[0] = rd1_m;
    assign o_rd1[1] = rd1_z;
    assign o_rd1[2] = {24'b0, rd1_s};
    assign o_rd2[0] = rd2_m;
    assign o_rd2[1] = rd2_z;
    assign o_rd2[2] = {24'b0, rd2_s};
    assign o_busy[0] = busy_m;
    assign o_busy[1] = busy_z;
    assign o_busy[2] = busy_s;

    // ---------------- reference model ----------------
    logic [31:0] m_mem [3][16];
    int          m_swept [3];     // sweep edges done so far, -1 when idle
    logic [31:0] e_rd1 [3];
    logic [31:0] e_rd2 [3];
    logic        e_busy [3];

    int total = 0;
    int bad   = 0;

    function automatic int depth_of(int k);
        return (k == 2) ? 8 : 16;
    endfunction

    function automatic logic [31:0] dmask_of(int k);
        return (k == 2) ? 32'h0000_00FF : 32'hFFFF_FFFF;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 16; i++) m_mem[k][i] = i & dmask_of(k);
            m_swept[k] = -1;
            e_rd1[k]   = '0;
            e_rd2[k]   = '0;
            e_busy[k]  = 1'b0;
        end
    endtask

    // One clock edge: advance the model with the inputs the DUT sampled,
    // then step 1 time unit past the edge so outputs can be sampled.
    task automatic cyc();
        @(posedge clk);
        if (!reset) begin
            for (int k = 0; k < 3; k++) begin
                int am;
                bit zr;
                am = depth_of(k) - 1;
                zr = (k == 1);
                if (m_swept[k] < 0) begin
                    if (we3 && !(zr && (a3 == 0))) m_mem[k][a3 & am] = wd3 & dmask_of(k);
                    if (we4 && !(zr && (a4 == 0))) m_mem[k][a4 & am] = wd4 & dmask_of(k);
                    if (clr) m_swept[k] = 0;
                end else begin
                    m_mem[k][m_swept[k]] = '0;
                    m_swept[k]++;
                    if (m_swept[k] == depth_of(k)) m_swept[k] = -1;
                end
                e_rd1[k]  = (zr && a1 == 0) ? 32'h0 : m_mem[k][a1 & am];
                e_rd2[k]  = (zr && a2 == 0) ? 32'h0 : m_mem[k][a2 & am];
                e_busy[k] = (m_swept[k] >= 0);
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        we3 = 1'b0; we4 = 1'b0; clr = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        model_reset();
        #1;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (o_rd1[k] !== 32'h0 || o_rd2[k] !== 32'h0 || o_busy[k] !== 1'b0) begin
                bad++;
                $display("FAIL reset_outputs[%0d] got rd1=%h rd2=%h busy=%b want 0/0/0",
                         k, o_rd1[k], o_rd2[k], o_busy[k]);
            end
        end
        cyc();
        cyc();
        reset = 1'b0;
        a1 = 4'd5; a2 = 4'd15;
        cyc();
        total++;
        if (rd1_m !== 32'd5 || rd2_m !== 32'd15) begin
            bad++;
            $display("FAIL reset_values got rd1=%h rd2=%h want 5/f", rd1_m, rd2_m);
        end
        total++;
        if (rd1_s !== 8'd5 || rd2_s !== 8'd7) begin
            bad++;
            $display("FAIL reset_values_small got rd1=%h rd2=%h want 5/7", rd1_s, rd2_s);
        end
    endtask

    task automatic test_bypass();
        we3 = 1'b1; a3 = 4'd7; wd3 = 32'hAAAA_0000;
        we4 = 1'b1; a4 = 4'd7; wd4 = 32'h5555_FFFF;
        a1 = 4'd7; a2 = 4'd6;
        cyc();
        total++;
        if (rd1_m !== 32'h5555_FFFF) begin
            bad++;
            $display("FAIL bypass_same_edge got=%h want=5555ffff", rd1_m);
        end
        total++;
        if (rd1_s !== 8'hFF) begin
            bad++;
            $display("FAIL bypass_small got=%h want=ff", rd1_s);
        end
        idle_inputs();
        cyc();
        total++;
        if (rd1_m !== 32'h5555_FFFF || rd2_m !== 32'd6) begin
            bad++;
            $display("FAIL bypass_next_edge got rd1=%h rd2=%h want 5555ffff/6", rd1_m, rd2_m);
        end
    endtask

    task automatic test_zero_reg();
        we3 = 1'b1; a3 = 4'd0; wd3 = 32'hDEAD_BEEF; a1 = 4'd0;
        cyc();
        total++;
        if (rd1_z !== 32'h0 || rd1_m !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL zero_bypass got z=%h m=%h want 0/deadbeef", rd1_z, rd1_m);
        end
        a3 = 4'd3;
        cyc();
        idle_inputs();
        a1 = 4'd0; a2 = 4'd3;
        cyc();
        total++;
        if (rd1_z !== 32'h0 || rd2_z !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL zero_reg got rd1=%h rd2=%h want 0/deadbeef", rd1_z, rd2_z);
        end
        total++;
        if (rd1_m !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL nonzero_entry0 got=%h want=deadbeef", rd1_m);
        end
    endtask

    task automatic test_clear();
        int busy_cnt;
        logic [31:0] exp15;
        a1 = 4'd15; a2 = 4'd2;
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        busy_cnt = o_busy[0] ? 1 : 0;
        for (int j = 1; j <= 20; j++) begin
            we3 = (j == 4); a3 = 4'd2; wd3 = 32'h0000_1234;
            clr = (j == 10);
            cyc();
            if (o_busy[0]) busy_cnt++;
            exp15 = (j < 16) ? 32'd15 : 32'd0;
            total++;
            if (rd1_m !== exp15) begin
                bad++;
                $display("FAIL sweep_read15 edge=%0d got=%h want=%h", j, rd1_m, exp15);
            end
            for (int k = 0; k < 3; k++) begin
                total++;
                if (o_rd1[k] !== e_rd1[k] || o_rd2[k] !== e_rd2[k] || o_busy[k] !== e_busy[k]) begin
                    bad++;
                    $display("FAIL sweep_model[%0d] edge=%0d got %h/%h/%b want %h/%h/%b", k, j,
                             o_rd1[k], o_rd2[k], o_busy[k], e_rd1[k], e_rd2[k], e_busy[k]);
                end
            end
        end
        idle_inputs();
        total++;
        if (busy_cnt !== 16) begin
            bad++;
            $display("FAIL clear_busy_cycles got=%0d want=16", busy_cnt);
        end
        a1 = 4'd2;
        cyc();
        total++;
        if (rd1_m !== 32'h0) begin
            bad++;
            $display("FAIL sweep_write_dropped got=%h want=0", rd1_m);
        end
        for (int j = 0; j < 10; j++) cyc();
    endtask

    task automatic test_reset_mid_sweep();
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        for (int j = 0; j < 6; j++) cyc();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (o_busy[k] !== 1'b0 || o_rd1[k] !== 32'h0) begin
                bad++;
                $display("FAIL reset_mid_sweep[%0d] got busy=%b rd1=%h want 0/0",
                         k, o_busy[k], o_rd1[k]);
            end
        end
        cyc();
        reset = 1'b0;
        a1 = 4'd3; a2 = 4'd10;
        cyc();
        total++;
        if (rd1_m !== 32'd3 || rd2_m !== 32'd10) begin
            bad++;
            $display("FAIL after_abort got rd1=%h rd2=%h want 3/a", rd1_m, rd2_m);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            a1  = 4'($urandom_range(0, 15));
            a2  = 4'($urandom_range(0, 15));
            a3  = 4'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(0, 15));
            a4  = ($urandom_range(0, 3) == 0) ? a3 : 4'($urandom_range(0, 15));
            we3 = 1'($urandom_range(0, 1));
            we4 = 1'($urandom_range(0, 1));
            wd3 = $urandom;
            wd4 = $urandom;
            clr = ($urandom_range(0, 59) == 0);
            cyc();
            for (int k = 0; k < 3; k++) begin
                total++;
                if (o_rd1[k] !== e_rd1[k] || o_rd2[k] !== e_rd2[k] || o_busy[k] !== e_busy[k]) begin
                    bad++;
                    $display("FAIL random[%0d] n=%0d got %h/%h/%b want %h/%h/%b", k, n,
                             o_rd1[k], o_rd2[k], o_busy[k], e_rd1[k], e_rd2[k], e_busy[k]);
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_small_params();
        int busy_cnt;
        reset = 1'b1;
        model_reset();
        cyc();
        reset = 1'b0;
        idle_inputs();
        a1 = 4'd7;
        cyc();
        total++;
        if (rd1_s !== 8'd7) begin
            bad++;
            $display("FAIL small_reset_entry7 got=%h want=07", rd1_s);
        end
        we3 = 1'b1; a3 = 4'd7; wd3 = 32'h0000_00FF;
        cyc();
        idle_inputs();
        cyc();
        total++;
        if (rd1_s !== 8'hFF) begin
            bad++;
            $display("FAIL small_write_ff got=%h want=ff", rd1_s);
        end
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        busy_cnt = o_busy[2] ? 1 : 0;
        for (int j = 0; j < 20; j++) begin
            cyc();
            if (o_busy[2]) busy_cnt++;
        end
        total++;
        if (busy_cnt !== 8) begin
            bad++;
            $display("FAIL small_clear_cycles got=%0d want=8", busy_cnt);
        end
        total++;
        if (rd1_s !== 8'h00 || busy_m !== 1'b0) begin
            bad++;
            $display("FAIL small_after_clear got rd1=%h busy_m=%b want 00/0", rd1_s, busy_m);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        model_reset();
        #2;
        test_reset();
        test_bypass();
        test_zero_reg();
        test_clear();
        test_reset_mid_sweep();
        test_random();
        test_small_params();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
